// File: rtl/clk_gate_ctrl.sv
// Auto clock-gating controller: counts idle cycles, runs a qreq/qack quiesce handshake and gates local_en.
// All outputs registered (one-cycle response to sampled inputs); the unit stalls gating by holding busy/wake_req or withholding qack.
module clk_gate_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_gate_en,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              qack,
  output logic              qreq,
  output logic              local_en,
  output logic              gated,
  output logic              wake_ack,
  output logic [15:0]       gate_cnt
);

  typedef enum logic [3:0] {
    ST_RUN   = 4'b0001,
    ST_QREQ  = 4'b0010,
    ST_GATED = 4'b0100,
    ST_WAKE  = 4'b1000
  } state_t;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_DLY - 1);

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [3:0]        wake_cnt;

  logic idle_cyc;
  logic thr_hit;
  logic q_abort;
  logic wake_go;

  assign idle_cyc = cfg_gate_en & ~busy & ~wake_req;
  // Compare one bit wider so a saturated counter still reaches any threshold.
  assign thr_hit  = (cfg_idle_thr != '0) &&
                    (({1'b0, idle_cnt} + (IDLE_W+1)'(1)) >= {1'b0, cfg_idle_thr});
  assign q_abort  = busy | wake_req | ~cfg_gate_en;
  assign wake_go  = wake_req | ~cfg_gate_en;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      qreq     <= 1'b0;
      local_en <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
      gate_cnt <= 16'd0;
    end else begin
      wake_ack <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (idle_cyc && thr_hit) begin
            state    <= ST_QREQ;
            qreq     <= 1'b1;
            idle_cnt <= '0;
          end else if (idle_cyc) begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + IDLE_W'(1);
          end else begin
            idle_cnt <= '0;
          end
        end
        ST_QREQ: begin
          // Abort outranks a coincident qack: the unit saw new work.
          if (q_abort) begin
            state <= ST_RUN;
            qreq  <= 1'b0;
          end else if (qack) begin
            state    <= ST_GATED;
            local_en <= 1'b0;
            gated    <= 1'b1;
            if (gate_cnt != 16'hFFFF) gate_cnt <= gate_cnt + 16'd1;
          end
        end
        ST_GATED: begin
          if (wake_go) begin
            state    <= ST_WAKE;
            local_en <= 1'b1;
            gated    <= 1'b0;
            wake_cnt <= WAKE_LAST;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == 4'd0) begin
            state    <= ST_RUN;
            qreq     <= 1'b0;
            wake_ack <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_RUN;
          idle_cnt <= '0;
          qreq     <= 1'b0;
          local_en <= 1'b1;
          gated    <= 1'b0;
        end
      endcase
    end
  end

endmodule
